// File: rtl/pla_exhaustive_driver.sv
// pla_exhaustive_driver: exhaustive vector source for a PLA with ones-count and MISR response compaction
module pla_exhaustive_driver #(
  parameter int N_IN = 9,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] SEED = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec_o,
  output logic             vec_valid,
  input  logic             vec_ready,
  input  logic             resp_i,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    ones_count,
  output logic [SIG_W-1:0] signature
);
  localparam logic [SIG_W-1:0] POLY = SIG_W'(16'h1021);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [SIG_W-1:0] sig_nxt;
  always_comb sig_nxt = {signature[SIG_W-2:0], 1'b0} ^ ((signature[SIG_W-1] ^ resp_i) ? POLY : '0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec_o      <= '0;
      vec_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
      signature  <= SEED;
    end else if (state != RUN) begin
      if (start) begin
        state      <= RUN;
        vec_o      <= '0;
        vec_valid  <= 1'b1;
        busy       <= 1'b1;
        done       <= 1'b0;
        ones_count <= '0;
        signature  <= SEED;
      end
    end else if (abort) begin
      state     <= IDLE;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (vec_ready) begin
      ones_count <= ones_count + (N_IN+1)'(resp_i);
      signature  <= sig_nxt;
      vec_o      <= vec_o + 1'b1;
      // the all-ones vector is the last one of the sweep
      if (&vec_o) begin
        state     <= DONE;
        vec_valid <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pla_exhaustive_driver.sv
// tb_pla_exhaustive_driver: directed scoreboard bench for pla_exhaustive_driver (N_IN=9 and N_IN=2)
module tb_pla_exhaustive_driver;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, vec_ready = 0, resp_one = 0;
  logic [8:0] vec_o;
  logic vec_valid, busy, done, resp_i;
  logic [9:0] ones_count;
  logic [15:0] signature;
  logic start2 = 0, ready2 = 0;
  logic [1:0] vec2;
  logic valid2, busy2, done2;
  logic [2:0] ones2;
  logic [15:0] sig2;
  int total = 0, passed = 0, failed = 0;
  typedef struct {
    logic [8:0]  v;
    logic [9:0]  o;
    logic [15:0] s;
    logic        b;
    logic        d;
    bit          cv;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  assign resp_i = resp_one | vec_o[0];

  pla_exhaustive_driver dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_o(vec_o), .vec_valid(vec_valid), .vec_ready(vec_ready), .resp_i(resp_i),
    .busy(busy), .done(done), .ones_count(ones_count), .signature(signature)
  );

  pla_exhaustive_driver #(.N_IN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
    .vec_o(vec2), .vec_valid(valid2), .vec_ready(ready2), .resp_i(vec2[0]),
    .busy(busy2), .done(done2), .ones_count(ones2), .signature(sig2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic r);
    return {s[14:0], 1'b0} ^ ((s[15] ^ r) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_vec"}, vec_o, 0);
    chk({tag, "_valid"}, vec_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ones"}, ones_count, 0);
    chk({tag, "_sig"}, signature, 16'hFFFF);
  endtask

  // act: 0 full run, 1 abort with a same-cycle transfer at vector 'at', 2 return while vector 'at' is presented
  task automatic run9(input bit stall, input int act, input int at, output int cyc, output logic [15:0] fsig);
    exp_t e;
    logic [8:0] ev;
    logic [9:0] eo;
    logic [15:0] es;
    logic eb, ed, r;
    bit cv;
    ev = 0; eo = 0; es = 16'hFFFF; eb = 1; ed = 0; cv = 1;
    start = 1; vec_ready = 0;
    tick;
    start = 0;
    cyc = 1;
    q.push_back('{ev, eo, es, eb, ed, cv});
    forever begin
      e = q.pop_front();
      if (e.cv) chk("vec_o", vec_o, e.v);
      chk("ones_count", ones_count, e.o);
      chk("signature", signature, e.s);
      chk("busy", busy, e.b);
      chk("vec_valid", vec_valid, e.b);
      chk("done", done, e.d);
      if (!e.b) break;
      if (act == 2 && ev == at) break;
      if (cyc > 2000) begin
        chk("timeout_cycles", cyc, 0);
        break;
      end
      vec_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      abort = (act == 1 && ev == at);
      if (abort) vec_ready = 1;
      r = resp_one | ev[0];
      if (abort) begin
        eb = 0;
        cv = 0;
      end else if (vec_ready) begin
        eo = eo + 10'(r);
        es = misr(es, r);
        ed = (ev == 9'h1FF);
        eb = !ed;
        ev = ev + 1'b1;
      end
      q.push_back('{ev, eo, es, eb, ed, cv});
      tick;
      abort = 0;
      cyc++;
    end
    fsig = signature;
  endtask

  initial begin
    int c;
    logic [15:0] s1, s2, s3, ref_sig;
    logic [15:0] seq [5];
    seq[0] = 16'hFFFF; seq[1] = 16'hEFDF; seq[2] = 16'hDFBE; seq[3] = 16'hAF5D; seq[4] = 16'h5EBA;
    tick;
    tick;
    rst_n = 1;
    chk_reset("reset");
    repeat (20) begin
      tick;
      chk("idle_valid", vec_valid, 0);
      chk("idle_sig", signature, 16'hFFFF);
    end
    // N_IN=2 sweep against the published signature sequence
    start2 = 1; ready2 = 1;
    tick;
    start2 = 0;
    for (int i = 0; i < 4; i++) begin
      chk("n2_vec", vec2, i);
      chk("n2_valid", valid2, 1);
      chk("n2_sig", sig2, seq[i]);
      tick;
    end
    chk("n2_sig_final", sig2, seq[4]);
    chk("n2_done", done2, 1);
    chk("n2_busy", busy2, 0);
    chk("n2_ones", ones2, 2);
    ready2 = 0;
    // full N_IN=9 run, then a repeat from DONE
    run9(0, 0, 0, c, s1);
    chk("run1_done_cycle", c, 513);
    chk("run1_ones", ones_count, 256);
    run9(0, 0, 0, c, s2);
    chk("run2_done_cycle", c, 513);
    chk("repeat_sig", s2, s1);
    // random stalls with all-ones responses
    resp_one = 1;
    ref_sig = 16'hFFFF;
    for (int i = 0; i < 512; i++) ref_sig = misr(ref_sig, 1'b1);
    run9(1, 0, 0, c, s3);
    chk("stall_ones", ones_count, 512);
    chk("stall_sig", s3, ref_sig);
    resp_one = 0;
    // abort at vector 100 together with a transfer
    run9(0, 1, 100, c, s1);
    chk("abort_ones", ones_count, 50);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    tick;
    chk("abort_hold_ones", ones_count, 50);
    run9(0, 0, 0, c, s2);
    chk("after_abort_cycle", c, 513);
    chk("after_abort_ones", ones_count, 256);
    // one-cycle reset at vector 300 with start asserted
    run9(0, 2, 300, c, s1);
    chk("pre_reset_vec", vec_o, 300);
    rst_n = 0; start = 1;
    tick;
    rst_n = 1; start = 0; vec_ready = 0;
    chk_reset("midrun_reset");
    repeat (3) tick;
    chk_reset("post_reset_idle");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
